// File: rtl/demux_scan_ctrl.sv
// Channel scan sequencer for the 1-to-4 demux: steps {a,b} through enabled channels with a programmable dwell.
// Optional break-before-make GAP cycle between channels is enabled by defining SCAN_GAP_EN.
module demux_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [3:0]         ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic               a,
   output logic               b,
   output logic               din,
   output logic               busy,
   output logic               done,
   output logic [7:0]         sweep_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
`ifdef SCAN_GAP_EN
   localparam logic [1:0] GAP    = 2'd2;
`endif

   logic [1:0]         state;
   logic [1:0]         sel;
   logic               mode_q;
   logic [3:0]         mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [2:0]         nxt;
   logic [1:0]         low_in;
   logic [1:0]         low_q;
   logic               last_cycle;

   // Returns {found, index} of the lowest enabled channel strictly above cur.
   function automatic logic [2:0] next_en(input logic [3:0] m, input logic [1:0] cur);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i > int'(cur) && m[i]) begin
            r = {1'b1, 2'(i)};
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] lowest(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) begin
            r = 2'(i);
         end
      end
      return r;
   endfunction

   always_comb begin
      nxt        = next_en(mask_q, sel);
      low_in     = lowest(ch_mask);
      low_q      = lowest(mask_q);
      last_cycle = (dwell_cnt == dwell_q - DWELL_W'(1));
   end

   assign a = sel[1];
   assign b = sel[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 2'd0;
         din       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sweep_cnt <= 8'd0;
         dwell_cnt <= '0;
         dwell_q   <= '0;
         mode_q    <= 1'b0;
         mask_q    <= 4'd0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && stop) begin
            state     <= IDLE;
            din       <= 1'b0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !stop && ch_mask != 4'd0) begin
                     state     <= ACTIVE;
                     sel       <= low_in;
                     din       <= 1'b1;
                     busy      <= 1'b1;
                     dwell_cnt <= '0;
                     mode_q    <= mode;
                     mask_q    <= ch_mask;
                     dwell_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
                     sweep_cnt <= 8'd0;
                  end
               end
               ACTIVE: begin
                  if (!last_cycle) begin
                     dwell_cnt <= dwell_cnt + DWELL_W'(1);
                  end else begin
                     dwell_cnt <= '0;
                     if (nxt[2]) begin
                        sel <= nxt[1:0];
`ifdef SCAN_GAP_EN
                        state <= GAP;
                        din   <= 1'b0;
`endif
                     end else begin
                        // End of a sweep: count it, then wrap or finish.
                        if (sweep_cnt != 8'hFF) begin
                           sweep_cnt <= sweep_cnt + 8'd1;
                        end
                        if (mode_q) begin
                           sel <= low_q;
`ifdef SCAN_GAP_EN
                           state <= GAP;
                           din   <= 1'b0;
`endif
                        end else begin
                           state <= IDLE;
                           din   <= 1'b0;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end
                  end
               end
`ifdef SCAN_GAP_EN
               GAP: begin
                  state <= ACTIVE;
                  din   <= 1'b1;
               end
`endif
               default: begin
                  state <= IDLE;
                  din   <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: a schedule-based reference model predicts every cycle's outputs.
// Honours SCAN_GAP_EN when defined, matching the DUT build.
module tb_demux_scan_ctrl;

`ifdef SCAN_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       mode;
   logic [3:0] ch_mask;
   logic [7:0] dwell;
   logic       a;
   logic       b;
   logic       din;
   logic       busy;
   logic       done;
   logic [7:0] sweep_cnt;

   always #5 clk = ~clk;

   demux_scan_ctrl #(.DWELL_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .ch_mask   (ch_mask),
      .dwell     (dwell),
      .a         (a),
      .b         (b),
      .din       (din),
      .busy      (busy),
      .done      (done),
      .sweep_cnt (sweep_cnt)
   );

   typedef struct {
      logic [1:0] idx;
      logic       din;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } exp_t;

   typedef struct {
      logic [1:0] idx;
      logic       din;
      logic       busy;
      logic       done;
      logic       inc;
   } step_t;

   exp_t  exp_q[$];
   step_t plan[$];
   int    total = 0;
   int    bad   = 0;

   int         m_idx = 0;
   int         m_cnt = 0;
   bit         m_mode = 1'b0;
   logic [3:0] m_mask = 4'd0;
   int         m_d = 1;

   function automatic step_t mkStep(int idx, bit d, bit bz, bit dn, bit inc);
      step_t s;
      s.idx  = 2'(idx);
      s.din  = d;
      s.busy = bz;
      s.done = dn;
      s.inc  = inc;
      return s;
   endfunction

   // One sweep as a list of per-cycle outputs; sweep_cnt bumps on the first cycle after a sweep ends.
   task automatic buildSweep(input bit first);
      int ch[$];
      for (int i = 0; i < 4; i++) begin
         if (m_mask[i]) ch.push_back(i);
      end
      for (int k = 0; k < ch.size(); k++) begin
         if (GAP_EN && (k > 0 || !first)) begin
            plan.push_back(mkStep(ch[k], 1'b0, 1'b1, 1'b0, (k == 0 && !first)));
         end
         for (int d = 0; d < m_d; d++) begin
            plan.push_back(mkStep(ch[k], 1'b1, 1'b1, 1'b0, (d == 0 && k == 0 && !first && !GAP_EN)));
         end
      end
      if (!m_mode) begin
         plan.push_back(mkStep(ch[ch.size()-1], 1'b0, 1'b0, 1'b1, 1'b1));
      end
   endtask

   task automatic popPlan(output exp_t e);
      step_t s;
      s = plan.pop_front();
      if (s.inc && m_cnt < 255) m_cnt++;
      m_idx  = int'(s.idx);
      e.idx  = s.idx;
      e.din  = s.din;
      e.busy = s.busy;
      e.done = s.done;
      e.cnt  = 8'(m_cnt);
      if (plan.size() == 0 && m_mode) buildSweep(1'b0);
   endtask

   task automatic modelStep(input bit r, input bit st, input bit sp, input bit md,
                            input logic [3:0] mk, input logic [7:0] dw, output exp_t e);
      e.idx  = 2'(m_idx);
      e.din  = 1'b0;
      e.busy = 1'b0;
      e.done = 1'b0;
      e.cnt  = 8'(m_cnt);
      if (!r) begin
         plan.delete();
         m_idx = 0;
         m_cnt = 0;
         e.idx = 2'd0;
         e.cnt = 8'd0;
      end else if (plan.size() > 0) begin
         if (sp) plan.delete();
         else popPlan(e);
      end else if (st && !sp && mk != 4'd0) begin
         m_mode = md;
         m_mask = mk;
         m_d    = (dw == 8'd0) ? 1 : int'(dw);
         m_cnt  = 0;
         buildSweep(1'b1);
         popPlan(e);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit st, input bit sp, input bit md,
                                input logic [3:0] mk, input logic [7:0] dw);
      exp_t e;
      @(negedge clk);
      rst_n   = r;
      start   = st;
      stop    = sp;
      mode    = md;
      ch_mask = mk;
      dwell   = dw;
      modelStep(r, st, sp, md, mk, dw, e);
      exp_q.push_back(e);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one expected entry per clock, compared just after the edge it describes.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sel",       {6'd0, a, b},      {6'd0, e.idx});
            checkOutput("din",       {7'd0, din},       {7'd0, e.din});
            checkOutput("busy",      {7'd0, busy},      {7'd0, e.busy});
            checkOutput("done",      {7'd0, done},      {7'd0, e.done});
            checkOutput("sweep_cnt", sweep_cnt,         e.cnt);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; ch_mask = 4'd0; dwell = 8'd0;

      $display("[TB] reset with start held");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'd3);
      idleCycles(2);

      $display("[TB] single sweep, all channels, dwell 3");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'd3);
      idleCycles(16);

      $display("[TB] continuous, mask 1010, dwell 0");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 8'd0);
      idleCycles(10);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      idleCycles(2);

      $display("[TB] start and stop together mid-scan");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 8'd4);
      idleCycles(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 8'd4);
      idleCycles(3);

      $display("[TB] ignored starts");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 8'd2);
      idleCycles(2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 8'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 8'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 8'd5);
      idleCycles(5);

      $display("[TB] start in done cycle");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 8'd1);
      idleCycles(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 8'd2);
      idleCycles(8);

      $display("[TB] sweep count saturation");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 8'd1);
      idleCycles(270);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      idleCycles(2);

      $display("[TB] reset mid-scan");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 8'd2);
      idleCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      idleCycles(2);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 39) == 0,
                       1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)),
                       8'($urandom_range(0, 4)));
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
